// File: rtl/video_box_overlay.sv
// -----------------------------------------------------------------------------
// video_box_overlay
//
// Pixel-stream stage sitting between the DVI receive decoder and the DVI
// transmit encoder, entirely in the pclk domain. It re-times the decoded
// RGB/sync/DE stream through two register stages, draws a fixed-colour
// rectangular outline onto active video, and measures the active width and
// height of each frame.
//
// Ports:
//   pclk                          pixel clock (decoder pclk)
//   reset                         synchronous, active-high
//   enable                        overlay request, taken at frame start only
//   red_in/green_in/blue_in       decoded pixel data, 8 bits each
//   hsync_in/vsync_in/de_in       decoded syncs and data enable
//   red_out/green_out/blue_out    pixel data to the encoder (2-cycle latency)
//   hsync_out/vsync_out/de_out    syncs and DE delayed by 2 cycles, unchanged
//   act_width                     active pixels in the last completed line
//   act_height                    active lines in the last completed frame
//   meas_valid                    act_width/act_height cover a full frame
// -----------------------------------------------------------------------------
module video_box_overlay #(
    parameter int          XW     = 12,
    parameter int          YW     = 12,
    parameter int          BOX_X0 = 100,
    parameter int          BOX_Y0 = 100,
    parameter int          BOX_W  = 200,
    parameter int          BOX_H  = 100,
    parameter int          BORDER = 2,
    parameter logic [23:0] COLOR  = 24'hFF0000,
    parameter logic        VS_POL = 1'b1
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    red_in,
    input  logic [7:0]    green_in,
    input  logic [7:0]    blue_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          de_in,
    output logic [7:0]    red_out,
    output logic [7:0]    green_out,
    output logic [7:0]    blue_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          de_out,
    output logic [XW-1:0] act_width,
    output logic [YW-1:0] act_height,
    output logic          meas_valid
);

    // Box limits held one bit wider than the counters so that
    // BOX_X0+BOX_W (and the Y equivalent) can never wrap back into range.
    localparam logic [XW:0] X_LO   = (XW+1)'(BOX_X0);
    localparam logic [XW:0] X_HI   = (XW+1)'(BOX_X0 + BOX_W);
    localparam logic [XW:0] X_LO_B = (XW+1)'(BOX_X0 + BORDER);
    localparam logic [XW:0] X_HI_B = (XW+1)'(BOX_X0 + BOX_W - BORDER);
    localparam logic [YW:0] Y_LO   = (YW+1)'(BOX_Y0);
    localparam logic [YW:0] Y_HI   = (YW+1)'(BOX_Y0 + BOX_H);
    localparam logic [YW:0] Y_LO_B = (YW+1)'(BOX_Y0 + BORDER);
    localparam logic [YW:0] Y_HI_B = (YW+1)'(BOX_Y0 + BOX_H - BORDER);

    // Stage 1: registered inputs plus the x/y position of that pixel.
    logic          r_de1;
    logic          r_hs1;
    logic          r_vs1;
    logic [23:0]   r_rgb1;
    logic [XW-1:0] r_x1;
    logic [YW-1:0] r_y1;
    logic          r_en_frame;
    logic          r_seen_fs;

    // Stage 2: muxed RGB and delayed syncs.
    logic          r_de2;
    logic          r_hs2;
    logic          r_vs2;
    logic [23:0]   r_rgb2;

    logic          w_line_end;
    logic          w_frame_start;
    logic [XW-1:0] w_x_inc;
    logic [YW-1:0] w_y_inc;
    logic [YW-1:0] w_y_after_le;
    logic [XW:0]   w_x_ext;
    logic [YW:0]   w_y_ext;
    logic          w_in_x;
    logic          w_in_y;
    logic          w_edge_x;
    logic          w_edge_y;
    logic          w_outline;

    // r_de1/r_vs1 hold the previous cycle's de_in/vsync_in, which gives the
    // edge history without extra registers.
    assign w_line_end    = r_de1 & ~de_in;
    assign w_frame_start = (vsync_in == VS_POL) && (r_vs1 != VS_POL);

    assign w_x_inc = (r_x1 == {XW{1'b1}}) ? r_x1 : r_x1 + XW'(1);
    assign w_y_inc = (r_y1 == {YW{1'b1}}) ? r_y1 : r_y1 + YW'(1);

    // A line ending in the same cycle as the frame start is counted before
    // the height is captured, so that line belongs to the finished frame.
    assign w_y_after_le = w_line_end ? w_y_inc : r_y1;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_de1      <= 1'b0;
            r_hs1      <= 1'b0;
            r_vs1      <= 1'b0;
            r_rgb1     <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_en_frame <= 1'b0;
            r_seen_fs  <= 1'b0;
            act_width  <= '0;
            act_height <= '0;
            meas_valid <= 1'b0;
        end else begin
            r_de1  <= de_in;
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;
            r_rgb1 <= {red_in, green_in, blue_in};

            // x restarts at 0 on the first DE-high cycle of each line.
            if (de_in) begin
                r_x1 <= r_de1 ? w_x_inc : '0;
            end else begin
                r_x1 <= '0;
            end

            if (w_line_end) begin
                act_width <= w_x_inc;
            end

            if (w_frame_start) begin
                act_height <= w_y_after_le;
                r_y1       <= '0;
                r_en_frame <= enable;
                r_seen_fs  <= 1'b1;
                // The first frame start after reset only opens a frame;
                // the second one closes a fully counted frame.
                if (r_seen_fs) begin
                    meas_valid <= 1'b1;
                end
            end else if (w_line_end) begin
                r_y1 <= w_y_inc;
            end
        end
    end

    assign w_x_ext = {1'b0, r_x1};
    assign w_y_ext = {1'b0, r_y1};

    assign w_in_x   = (w_x_ext >= X_LO) && (w_x_ext < X_HI);
    assign w_in_y   = (w_y_ext >= Y_LO) && (w_y_ext < Y_HI);
    assign w_edge_x = (w_x_ext < X_LO_B) || (w_x_ext >= X_HI_B);
    assign w_edge_y = (w_y_ext < Y_LO_B) || (w_y_ext >= Y_HI_B);

    assign w_outline = r_de1 && r_en_frame && w_in_x && w_in_y
                       && (w_edge_x || w_edge_y);

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_de2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_rgb2 <= '0;
        end else begin
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_rgb2 <= w_outline ? COLOR : r_rgb1;
        end
    end

    assign red_out   = r_rgb2[23:16];
    assign green_out = r_rgb2[15:8];
    assign blue_out  = r_rgb2[7:0];
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;
    assign de_out    = r_de2;

endmodule

// File: tb/tb_video_box_overlay.sv
// -----------------------------------------------------------------------------
// tb_video_box_overlay
//
// Drives a small 16x8 video timing into two overlay instances that share the
// input stream: one with an interior 6x4 box, one with a box clipped by the
// right edge of the frame. Every driven pixel pushes its expected output
// record; records are popped two cycles later when the pipeline delivers
// the matching output. Measurement outputs are checked at frame boundaries
// and around resets.
// -----------------------------------------------------------------------------
module tb_video_box_overlay;

    logic        pclk;
    logic        reset;
    logic        enable;
    logic [7:0]  red_in, green_in, blue_in;
    logic        hsync_in, vsync_in, de_in;

    logic [7:0]  red_out, green_out, blue_out;
    logic        hsync_out, vsync_out, de_out;
    logic [11:0] act_width;
    logic [11:0] act_height;
    logic        meas_valid;

    logic [7:0]  c_red_out, c_green_out, c_blue_out;
    logic        c_hsync_out, c_vsync_out, c_de_out;
    logic [11:0] c_act_width;
    logic [11:0] c_act_height;
    logic        c_meas_valid;

    int checks   = 0;
    int failures = 0;

    // {hs, vs, de, rgb_box, rgb_clip}
    logic [50:0] exp_q[$];

    bit m_en     = 1'b0;
    bit prev_vs  = 1'b0;
    bit post_rst = 1'b0;

    video_box_overlay #(
        .XW(12), .YW(12),
        .BOX_X0(2), .BOX_Y0(1), .BOX_W(6), .BOX_H(4), .BORDER(1),
        .COLOR(24'hFF0000), .VS_POL(1'b1)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .act_width(act_width), .act_height(act_height), .meas_valid(meas_valid)
    );

    video_box_overlay #(
        .XW(12), .YW(12),
        .BOX_X0(14), .BOX_Y0(1), .BOX_W(6), .BOX_H(7), .BORDER(2),
        .COLOR(24'hFF0000), .VS_POL(1'b1)
    ) dut_clip (
        .pclk(pclk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .red_out(c_red_out), .green_out(c_green_out), .blue_out(c_blue_out),
        .hsync_out(c_hsync_out), .vsync_out(c_vsync_out), .de_out(c_de_out),
        .act_width(c_act_width), .act_height(c_act_height), .meas_valid(c_meas_valid)
    );

    // Clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected outline of the 6x4 box at (2,1), one pixel thick.
    function automatic bit box_a(input int x, input int y);
        return (((y == 1) || (y == 4)) && (x >= 2) && (x <= 7)) ||
               (((x == 2) || (x == 7)) && (y >= 2) && (y <= 3));
    endfunction

    // One pclk step: compare the output due now, then drive the next input.
    task automatic step(input logic rst, input logic en_v, input logic hs,
                        input logic vs, input logic de, input logic [23:0] rgb,
                        input int x, input int y);
        logic [50:0] exp_v;
        logic [50:0] obs_v;
        logic [23:0] ea;
        logic [23:0] ec;
        @(negedge pclk);
        if (exp_q.size() >= 2) begin
            exp_v = exp_q.pop_front();
            obs_v = {hsync_out, vsync_out, de_out, red_out, green_out, blue_out,
                     c_red_out, c_green_out, c_blue_out};
            checks++;
            assert (obs_v === exp_v) else begin
                failures++;
                $error("FAIL pixel observed=%h expected=%h", obs_v, exp_v);
            end
        end
        if (post_rst) begin
            chk("rst_act_width", 32'(act_width), 32'd0);
            chk("rst_act_height", 32'(act_height), 32'd0);
            chk("rst_meas_valid", 32'(meas_valid), 32'd0);
        end
        post_rst = rst;

        reset    = rst;
        enable   = en_v;
        hsync_in = hs;
        vsync_in = vs;
        de_in    = de;
        {red_in, green_in, blue_in} = rgb;

        if (rst) begin
            // Both pipeline stages are cleared by this edge.
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            prev_vs = 1'b0;
            m_en    = 1'b0;
        end else begin
            if (vs && !prev_vs) m_en = en_v;
            prev_vs = vs;
            ea = (de && m_en && box_a(x, y)) ? 24'hFF0000 : rgb;
            ec = (de && m_en && (x >= 14) && (y >= 1)) ? 24'hFF0000 : rgb;
            exp_q.push_back({hs, vs, de, ea, ec});
        end
    endtask

    // Frame: 2 vsync lines, 1 porch line, 8 active lines of 16+4 pixels.
    task automatic send_frame(input bit en_start, input int tog_line, input bit tog_val,
                              input int rst_line, input bit short_tail, input bit const_rgb);
        logic        en_v;
        logic [23:0] rgb;
        en_v = en_start;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 20; c++) begin
                rgb = const_rgb ? 24'h101010 : 24'($urandom_range(0, 24'hFFFFFF));
                step(1'b0, en_v, 1'b0, (l < 2), 1'b0, rgb, 0, 0);
            end
        end
        for (int y = 0; y < 8; y++) begin
            for (int c = 0; c < 20; c++) begin
                if (short_tail && (y == 7) && (c >= 16)) break;
                if ((y == tog_line) && (c == 0)) en_v = tog_val;
                rgb = const_rgb ? 24'h101010 : 24'($urandom_range(0, 24'hFFFFFF));
                step((y == rst_line) && (c == 5), en_v, (c == 17) || (c == 18),
                     1'b0, (c < 16), rgb, c, y);
            end
        end
    endtask

    task automatic chk_meas(input string tag, input bit mv);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 32'(mv));
        if (mv) begin
            chk({tag, "_act_width"}, 32'(act_width), 32'd16);
            chk({tag, "_act_height"}, 32'(act_height), 32'd8);
            chk({tag, "_clip_act_width"}, 32'(c_act_width), 32'd16);
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in    = 1'b0;
        {red_in, green_in, blue_in} = 24'h0;

        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);

        // Frames 1-2: box on, constant grey input; measurement becomes valid.
        send_frame(1'b1, -1, 1'b0, -1, 1'b0, 1'b1);
        chk_meas("f1", 1'b0);
        chk("f1_act_width", 32'(act_width), 32'd16);
        send_frame(1'b1, -1, 1'b0, -1, 1'b0, 1'b1);
        chk_meas("f2", 1'b1);

        // Frame 3: enable raised mid-frame, no box until the next frame.
        send_frame(1'b0, 3, 1'b1, -1, 1'b0, 1'b0);
        // Frame 4: enable dropped mid-frame, box persists to frame end.
        send_frame(1'b1, 4, 1'b0, -1, 1'b0, 1'b0);
        // Frame 5: box absent; last DE fall coincides with next vsync edge.
        send_frame(1'b0, -1, 1'b0, -1, 1'b1, 1'b0);
        // Frame 6: height captured at that coincident edge includes the line.
        send_frame(1'b1, -1, 1'b0, -1, 1'b0, 1'b0);
        chk_meas("f6", 1'b1);

        // Frame 7: one-cycle reset mid-line 3.
        send_frame(1'b1, -1, 1'b0, 3, 1'b0, 1'b0);
        chk_meas("f7", 1'b0);
        send_frame(1'b1, -1, 1'b0, -1, 1'b0, 1'b0);
        chk_meas("f8", 1'b0);
        send_frame(1'b1, -1, 1'b0, -1, 1'b0, 1'b0);
        chk_meas("f9", 1'b1);

        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
